metronome_gen: RTL and testbench

METRONOME_GEN -- requirements
Module: metronome_gen

---
 rtl/metronome_pkg.sv | 33 +++
 rtl/metronome_tempo.sv | 62 ++++++
 rtl/metronome_gen.sv | 175 +++++++++++++++++
 tb/tb_metronome_gen.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
// Shared types and compile-time helpers for the metronome.
//   state_e        : beat-sequencer FSM states
//   click_cycles() : clock cycles per audible click
//   half_period()  : clock cycles per half-period of a tone
//   beat_threshold(): phase-accumulator wrap value (one beat = 60 * CLK_HZ bpm-cycles)
package metronome_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StClick
   } state_e;

   function automatic int unsigned click_cycles(input int unsigned clk_hz,
                                                input int unsigned click_ms);
      int unsigned cyc;
      cyc = (clk_hz / 1000) * click_ms;
      // A zero-length click would leave the FSM stuck in StClick.
      return (cyc == 32'd0) ? 32'd1 : cyc;
   endfunction

   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input int unsigned tone_hz);
      int unsigned hp;
      hp = clk_hz / (2 * tone_hz);
      return (hp == 32'd0) ? 32'd1 : hp;
   endfunction

   function automatic int unsigned beat_threshold(input int unsigned clk_hz);
      return clk_hz * 60;
   endfunction

endpackage

// File: rtl/metronome_tempo.sv
// Tempo register with one saturating step per cycle.
//   clk            : system clock
//   rst            : synchronous active-high reset, loads BPM_RST
//   bpm_dn1/bpm_up1/bpm_dn10/bpm_up10 : step pulses, in that priority order
//   bpm            : current tempo, always within [BPM_MIN, BPM_MAX]
module metronome_tempo #(
   parameter int unsigned BPM_MIN = 30,
   parameter int unsigned BPM_MAX = 250,
   parameter int unsigned BPM_RST = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bpm_up1,
   input  logic       bpm_dn1,
   input  logic       bpm_up10,
   input  logic       bpm_dn10,
   output logic [7:0] bpm
);

   import metronome_pkg::*;

   logic [7:0] bpm_q, bpm_d;

   // Widened to 10 bits so the bound checks cannot wrap.
   function automatic logic [7:0] step_down(input logic [7:0] cur, input logic [7:0] step);
      if ({2'b00, cur} < ({2'b00, step} + 10'(BPM_MIN))) begin
         return 8'(BPM_MIN);
      end
      return cur - step;
   endfunction

   function automatic logic [7:0] step_up(input logic [7:0] cur, input logic [7:0] step);
      if (({2'b00, cur} + {2'b00, step}) > 10'(BPM_MAX)) begin
         return 8'(BPM_MAX);
      end
      return cur + step;
   endfunction

   always_comb begin
      bpm_d = bpm_q;
      if (bpm_dn1) begin
         bpm_d = step_down(bpm_q, 8'd1);
      end else if (bpm_up1) begin
         bpm_d = step_up(bpm_q, 8'd1);
      end else if (bpm_dn10) begin
         bpm_d = step_down(bpm_q, 8'd10);
      end else if (bpm_up10) begin
         bpm_d = step_up(bpm_q, 8'd10);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bpm_q <= 8'(BPM_RST);
      end else begin
         bpm_q <= bpm_d;
      end
   end

   assign bpm = bpm_q;

endmodule

// File: rtl/metronome_gen.sv
// Metronome: phase-accumulator beat timing, bar counter and square-wave click tone.
//   clk            : system clock, all state on rising edge
//   rst            : synchronous active-high reset
//   play           : 1 = run, 0 = pause
//   bpm_up1/bpm_dn1/bpm_up10/bpm_dn10 : single-cycle tempo steps
//   beats_per_bar  : bar length, 0 or 1 disables the accent
//   bpm            : current tempo
//   beat           : one-cycle strobe in the first cycle of each click
//   accent         : high for the whole click of a downbeat
//   beat_idx       : position of the current beat within the bar
//   bell           : square-wave tone, low outside clicks
module metronome_gen #(
   parameter int unsigned CLK_HZ    = 25_000_000,
   parameter int unsigned TONE_HZ   = 2500,
   parameter int unsigned ACCENT_HZ = 5000,
   parameter int unsigned CLICK_MS  = 40,
   parameter int unsigned BPM_MIN   = 30,
   parameter int unsigned BPM_MAX   = 250,
   parameter int unsigned BPM_RST   = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       play,
   input  logic       bpm_up1,
   input  logic       bpm_dn1,
   input  logic       bpm_up10,
   input  logic       bpm_dn10,
   input  logic [3:0] beats_per_bar,
   output logic [7:0] bpm,
   output logic       beat,
   output logic       accent,
   output logic [3:0] beat_idx,
   output logic       bell
);

   import metronome_pkg::*;

   localparam int unsigned ClickCyc   = click_cycles(CLK_HZ, CLICK_MS);
   localparam int unsigned ToneHalf   = half_period(CLK_HZ, TONE_HZ);
   localparam int unsigned AccentHalf = half_period(CLK_HZ, ACCENT_HZ);
   localparam logic [31:0] Thresh     = beat_threshold(CLK_HZ);
   localparam int unsigned ClickW     = $clog2(ClickCyc + 1);
   localparam int unsigned ToneMax    = (ToneHalf > AccentHalf) ? ToneHalf : AccentHalf;
   localparam int unsigned ToneW      = $clog2(ToneMax + 1);

   state_e            state_q, state_d;
   logic [31:0]       acc_q, acc_d;
   logic [ClickW-1:0] click_cnt_q, click_cnt_d;
   logic [ToneW-1:0]  tone_cnt_q, tone_cnt_d;
   logic              bell_q, bell_d;
   logic              beat_q, beat_d;
   logic [3:0]        beat_idx_q, beat_idx_d;
   logic              first_q, first_d;

   logic [7:0]        bpm_w;
   logic [32:0]       acc_sum;
   logic              overflow;
   logic              start_beat;
   logic              accent_w;
   logic [ToneW-1:0]  tone_last;
   logic [4:0]        idx_inc;
   logic [3:0]        idx_next;

   metronome_tempo #(
      .BPM_MIN (BPM_MIN),
      .BPM_MAX (BPM_MAX),
      .BPM_RST (BPM_RST)
   ) u_tempo (
      .clk      (clk),
      .rst      (rst),
      .bpm_up1  (bpm_up1),
      .bpm_dn1  (bpm_dn1),
      .bpm_up10 (bpm_up10),
      .bpm_dn10 (bpm_dn10),
      .bpm      (bpm_w)
   );

   // Uses the registered tempo, so a step lands on the following cycle's addition.
   assign acc_sum  = {1'b0, acc_q} + {25'd0, bpm_w};
   assign overflow = (acc_sum >= {1'b0, Thresh});

   assign accent_w  = (state_q == StClick) && (beat_idx_q == 4'd0) && (beats_per_bar >= 4'd2);
   assign tone_last = accent_w ? ToneW'(AccentHalf - 1) : ToneW'(ToneHalf - 1);

   // beats_per_bar of 0 or 1 always compares true, pinning the index at 0.
   assign idx_inc  = {1'b0, beat_idx_q} + 5'd1;
   assign idx_next = (idx_inc >= {1'b0, beats_per_bar}) ? 4'd0 : idx_inc[3:0];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      click_cnt_d = '0;
      tone_cnt_d  = '0;
      bell_d      = 1'b0;
      beat_d      = 1'b0;
      beat_idx_d  = beat_idx_q;
      first_d     = first_q;
      start_beat  = 1'b0;

      case (state_q)
         StIdle: begin
            if (play) begin
               state_d    = StClick;
               acc_d      = '0;
               start_beat = 1'b1;
            end
         end
         StWait, StClick: begin
            if (!play) begin
               // Pause: acc and beat_idx hold, tone and counters drop.
               state_d = StIdle;
            end else if (overflow) begin
               acc_d      = acc_sum[31:0] - Thresh;
               state_d    = StClick;
               start_beat = 1'b1;
            end else begin
               acc_d = acc_sum[31:0];
               if (state_q == StClick) begin
                  if (click_cnt_q == ClickW'(ClickCyc - 1)) begin
                     state_d = StWait;
                  end else begin
                     click_cnt_d = click_cnt_q + 1'b1;
                     if (tone_cnt_q >= tone_last) begin
                        bell_d = ~bell_q;
                     end else begin
                        tone_cnt_d = tone_cnt_q + 1'b1;
                        bell_d     = bell_q;
                     end
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Every beat starts a fresh click with the tone low and counters cleared.
      if (start_beat) begin
         beat_d = 1'b1;
         if (first_q) begin
            first_d = 1'b0;
         end else begin
            beat_idx_d = idx_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         click_cnt_q <= '0;
         tone_cnt_q  <= '0;
         bell_q      <= 1'b0;
         beat_q      <= 1'b0;
         beat_idx_q  <= '0;
         first_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         click_cnt_q <= click_cnt_d;
         tone_cnt_q  <= tone_cnt_d;
         bell_q      <= bell_d;
         beat_q      <= beat_d;
         beat_idx_q  <= beat_idx_d;
         first_q     <= first_d;
      end
   end

   assign bpm      = bpm_w;
   assign beat     = beat_q;
   assign accent   = accent_w;
   assign beat_idx = beat_idx_q;
   assign bell     = bell_q;

endmodule

// File: tb/tb_metronome_gen.sv
// Directed bench for metronome_gen at CLK_HZ=6000 (one beat = 6000 cycles at 60 bpm).
// A second instance with a 1500 ms click exercises click restart on overflow.
module tb_metronome_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       play = 1'b0;
   logic       bpm_up1 = 1'b0;
   logic       bpm_dn1 = 1'b0;
   logic       bpm_up10 = 1'b0;
   logic       bpm_dn10 = 1'b0;
   logic [3:0] beats_per_bar = 4'd0;

   logic [7:0] bpm, l_bpm;
   logic       beat, l_beat;
   logic       accent, l_accent;
   logic [3:0] beat_idx, l_beat_idx;
   logic       bell, l_bell;

   int n_checks = 0;
   int n_fail = 0;

   metronome_gen #(
      .CLK_HZ    (6000),
      .TONE_HZ   (500),
      .ACCENT_HZ (1000),
      .CLICK_MS  (100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .play          (play),
      .bpm_up1       (bpm_up1),
      .bpm_dn1       (bpm_dn1),
      .bpm_up10      (bpm_up10),
      .bpm_dn10      (bpm_dn10),
      .beats_per_bar (beats_per_bar),
      .bpm           (bpm),
      .beat          (beat),
      .accent        (accent),
      .beat_idx      (beat_idx),
      .bell          (bell)
   );

   metronome_gen #(
      .CLK_HZ    (6000),
      .TONE_HZ   (500),
      .ACCENT_HZ (1000),
      .CLICK_MS  (1500)
   ) dut_long (
      .clk           (clk),
      .rst           (rst),
      .play          (play),
      .bpm_up1       (bpm_up1),
      .bpm_dn1       (bpm_dn1),
      .bpm_up10      (bpm_up10),
      .bpm_dn10      (bpm_dn10),
      .beats_per_bar (beats_per_bar),
      .bpm           (l_bpm),
      .beat          (l_beat),
      .accent        (l_accent),
      .beat_idx      (l_beat_idx),
      .bell          (l_bell)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      play = 1'b0;
      bpm_up1 = 1'b0;
      bpm_dn1 = 1'b0;
      bpm_up10 = 1'b0;
      bpm_dn10 = 1'b0;
      tick_n(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      n_checks++;
      if (bpm !== 8'd60) begin
         n_fail++; $display("FAIL reset_bpm: got %0d expected 60", bpm);
      end
      n_checks++;
      if ({beat, accent, bell} !== 3'b000) begin
         n_fail++; $display("FAIL reset_outs: got beat/accent/bell %b expected 000",
                            {beat, accent, bell});
      end
      n_checks++;
      if (beat_idx !== 4'd0) begin
         n_fail++; $display("FAIL reset_idx: got %0d expected 0", beat_idx);
      end
      // Idle with play low: no beat may appear.
      tick_n(20);
      n_checks++;
      if ({beat, bell, l_beat, l_bell} !== 4'b0000) begin
         n_fail++; $display("FAIL idle_quiet: got %b expected 0000", {beat, bell, l_beat, l_bell});
      end
   endtask

   task automatic test_basic();
      int bell_err;
      int beat_err;
      logic exp_bell;
      logic exp_beat;
      reset_dut();
      beats_per_bar = 4'd0;
      play = 1'b1;
      tick();
      n_checks++;
      if (beat !== 1'b1 || bell !== 1'b0) begin
         n_fail++; $display("FAIL basic_first_beat: got beat=%b bell=%b expected 1 0", beat, bell);
      end
      bell_err = 0;
      beat_err = 0;
      for (int k = 1; k <= 6000; k++) begin
         tick();
         exp_bell = (k < 600) ? (((k / 6) % 2) == 1) : 1'b0;
         exp_beat = (k == 6000);
         if (bell !== exp_bell) bell_err++;
         if (beat !== exp_beat) beat_err++;
         if (k == 6 || k == 599) begin
            n_checks++;
            if (bell !== 1'b1) begin
               n_fail++; $display("FAIL basic_bell_high_%0d: got %b expected 1", k, bell);
            end
         end
      end
      n_checks++;
      if (bell_err !== 0) begin
         n_fail++; $display("FAIL basic_bell_pattern: got %0d bad cycles expected 0", bell_err);
      end
      n_checks++;
      if (beat_err !== 0) begin
         n_fail++; $display("FAIL basic_beat_period: got %0d bad cycles expected 0", beat_err);
      end
      n_checks++;
      if (accent !== 1'b0 || beat_idx !== 4'd0) begin
         n_fail++; $display("FAIL basic_no_accent: got accent=%b idx=%0d expected 0 0",
                            accent, beat_idx);
      end
   endtask

   task automatic test_accent();
      logic exp_acc;
      reset_dut();
      beats_per_bar = 4'd4;
      play = 1'b1;
      tick();
      for (int n = 0; n <= 4; n++) begin
         exp_acc = ((n % 4) == 0);
         n_checks++;
         if (beat !== 1'b1 || beat_idx !== 4'(n % 4) || accent !== exp_acc) begin
            n_fail++;
            $display("FAIL accent_beat_%0d: got beat=%b idx=%0d acc=%b expected 1 %0d %b",
                     n, beat, beat_idx, accent, n % 4, exp_acc);
         end
         // Offset 3: accent tone (half 3) is already high, normal tone (half 6) still low.
         tick_n(3);
         n_checks++;
         if (bell !== exp_acc) begin
            n_fail++; $display("FAIL accent_tone_%0d: got bell=%b expected %b", n, bell, exp_acc);
         end
         tick_n(597);
         n_checks++;
         if (accent !== 1'b0 || bell !== 1'b0) begin
            n_fail++; $display("FAIL accent_wait_%0d: got acc=%b bell=%b expected 0 0",
                               n, accent, bell);
         end
         if (n < 4) tick_n(5400);
      end
   endtask

   task automatic test_tempo();
      reset_dut();
      bpm_dn10 = 1'b1;
      tick_n(3);
      n_checks++;
      if (bpm !== 8'd30) begin
         n_fail++; $display("FAIL tempo_dn10x3: got %0d expected 30", bpm);
      end
      tick();
      bpm_dn10 = 1'b0;
      n_checks++;
      if (bpm !== 8'd30) begin
         n_fail++; $display("FAIL tempo_min_sat: got %0d expected 30", bpm);
      end
      bpm_dn1 = 1'b1;
      tick();
      bpm_dn1 = 1'b0;
      n_checks++;
      if (bpm !== 8'd30) begin
         n_fail++; $display("FAIL tempo_dn1_min: got %0d expected 30", bpm);
      end
      bpm_up10 = 1'b1;
      tick_n(25);
      bpm_up10 = 1'b0;
      n_checks++;
      if (bpm !== 8'd250) begin
         n_fail++; $display("FAIL tempo_up10x25: got %0d expected 250", bpm);
      end
      bpm_up1 = 1'b1;
      tick();
      n_checks++;
      if (bpm !== 8'd250) begin
         n_fail++; $display("FAIL tempo_up1_max: got %0d expected 250", bpm);
      end
      bpm_dn1 = 1'b1;
      tick();
      bpm_dn1 = 1'b0;
      bpm_up1 = 1'b0;
      n_checks++;
      if (bpm !== 8'd249) begin
         n_fail++; $display("FAIL tempo_up1_dn1: got %0d expected 249", bpm);
      end
      bpm_dn10 = 1'b1;
      bpm_up10 = 1'b1;
      tick();
      bpm_up10 = 1'b0;
      n_checks++;
      if (bpm !== 8'd239) begin
         n_fail++; $display("FAIL tempo_dn10_up10: got %0d expected 239", bpm);
      end
      bpm_up1 = 1'b1;
      tick();
      bpm_up1 = 1'b0;
      bpm_dn10 = 1'b0;
      n_checks++;
      if (bpm !== 8'd240) begin
         n_fail++; $display("FAIL tempo_up1_over_dn10: got %0d expected 240", bpm);
      end
   endtask

   task automatic test_pause();
      int bad;
      reset_dut();
      beats_per_bar = 4'd4;
      play = 1'b1;
      tick();
      tick_n(6000);
      tick_n(306);
      n_checks++;
      if (bell !== 1'b1 || beat_idx !== 4'd1) begin
         n_fail++; $display("FAIL pause_before: got bell=%b idx=%0d expected 1 1", bell, beat_idx);
      end
      play = 1'b0;
      tick();
      n_checks++;
      if (bell !== 1'b0 || accent !== 1'b0) begin
         n_fail++; $display("FAIL pause_bell_off: got bell=%b acc=%b expected 0 0", bell, accent);
      end
      bad = 0;
      for (int i = 1; i < 1000; i++) begin
         tick();
         if (beat !== 1'b0 || bell !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0 || beat_idx !== 4'd1) begin
         n_fail++; $display("FAIL pause_hold: got %0d active cycles idx=%0d expected 0 1",
                            bad, beat_idx);
      end
      play = 1'b1;
      tick();
      n_checks++;
      if (beat !== 1'b1 || beat_idx !== 4'd2 || bell !== 1'b0) begin
         n_fail++; $display("FAIL pause_resume: got beat=%b idx=%0d bell=%b expected 1 2 0",
                            beat, beat_idx, bell);
      end
      tick_n(6);
      n_checks++;
      if (bell !== 1'b1) begin
         n_fail++; $display("FAIL pause_resume_tone: got %b expected 1", bell);
      end
   endtask

   task automatic test_long_click();
      reset_dut();
      beats_per_bar = 4'd0;
      play = 1'b1;
      tick();
      n_checks++;
      if (l_beat !== 1'b1) begin
         n_fail++; $display("FAIL long_first_beat: got %b expected 1", l_beat);
      end
      tick_n(5999);
      n_checks++;
      if (l_beat !== 1'b0 || l_bell !== 1'b1) begin
         n_fail++; $display("FAIL long_pre_overflow: got beat=%b bell=%b expected 0 1",
                            l_beat, l_bell);
      end
      tick();
      n_checks++;
      if (l_beat !== 1'b1 || l_bell !== 1'b0) begin
         n_fail++; $display("FAIL long_overflow_beat: got beat=%b bell=%b expected 1 0",
                            l_beat, l_bell);
      end
      // Original click would have ended at offset 9000; a restarted one still sounds.
      tick_n(3006);
      n_checks++;
      if (l_bell !== 1'b1) begin
         n_fail++; $display("FAIL long_click_restart: got bell=%b expected 1", l_bell);
      end
   endtask

   task automatic test_reset_mid_click();
      reset_dut();
      beats_per_bar = 4'd4;
      bpm_up1 = 1'b1;
      tick();
      bpm_up1 = 1'b0;
      n_checks++;
      if (bpm !== 8'd61) begin
         n_fail++; $display("FAIL rstmid_idle_step: got %0d expected 61", bpm);
      end
      play = 1'b1;
      tick();
      tick_n(105);
      n_checks++;
      if (accent !== 1'b1 || bell !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_before: got acc=%b bell=%b expected 1 1", accent, bell);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({beat, accent, bell} !== 3'b000 || beat_idx !== 4'd0 || bpm !== 8'd60) begin
         n_fail++;
         $display("FAIL rstmid_outs: got beat/acc/bell=%b idx=%0d bpm=%0d expected 000 0 60",
                  {beat, accent, bell}, beat_idx, bpm);
      end
      tick();
      n_checks++;
      if (beat !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_hold: got beat=%b expected 0", beat);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (beat !== 1'b1 || beat_idx !== 4'd0 || accent !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_restart: got beat=%b idx=%0d acc=%b expected 1 0 1",
                            beat, beat_idx, accent);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_accent();
      test_tempo();
      test_pause();
      test_long_click();
      test_reset_mid_click();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
